// File: rtl/sprite_drawer_if.sv
// Bundle of the sprite drawer's signals: draw command/status, sprite ROM port and VGA write port.
// The drawer uses the slave view; whoever issues draws and serves the ROM uses the master view.
interface sprite_drawer_if #(
  parameter int WIDTH_X = 4,
  parameter int WIDTH_Y = 3
);
  logic               start;
  logic [7:0]         pos_x;
  logic [6:0]         pos_y;
  logic               busy;
  logic               done;
  logic [WIDTH_X-1:0] rom_x;
  logic [WIDTH_Y-1:0] rom_y;
  logic [2:0]         rom_color;
  logic [7:0]         vga_x;
  logic [6:0]         vga_y;
  logic [2:0]         vga_color;
  logic               plot;

  modport master (
    output start, pos_x, pos_y, rom_color,
    input  busy, done, rom_x, rom_y, vga_x, vga_y, vga_color, plot
  );

  modport slave (
    input  start, pos_x, pos_y, rom_color,
    output busy, done, rom_x, rom_y, vga_x, vga_y, vga_color, plot
  );
endinterface

// File: rtl/sprite_drawer.sv
// Copies a SPRITE_W x SPRITE_H sprite from a ROM with one-cycle read latency to a VGA
// write port at a given screen position, clipping off-screen and transparent pixels.
module sprite_drawer #(
  parameter int       WIDTH_X        = 4,
  parameter int       WIDTH_Y        = 3,
  parameter int       SPRITE_W       = 10,
  parameter int       SPRITE_H       = 6,
  parameter int       SCREEN_W       = 160,
  parameter int       SCREEN_H       = 120,
  parameter bit [2:0] TRANSPARENT    = 3'b000,
  parameter bit       TRANSPARENT_EN = 1'b1
) (
  input  logic           clk,
  input  logic           resetn,
  sprite_drawer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH_X-1:0] sx_reg, sx_next;
  logic [WIDTH_Y-1:0] sy_reg, sy_next;
  logic [7:0]         pos_x_reg, pos_x_next;
  logic [6:0]         pos_y_reg, pos_y_next;
  logic               flush_reg, flush_next;

  // Stage 1: screen coordinate of the address issued last cycle (ROM data arrives now).
  logic               valid1_reg;
  logic [8:0]         x1_reg;
  logic [7:0]         y1_reg;

  // Stage 2: registered VGA write port.
  logic               plot_reg;
  logic [7:0]         vga_x_reg;
  logic [6:0]         vga_y_reg;
  logic [2:0]         vga_color_reg;

  logic               last_col;
  logic               last_row;
  logic               on_screen;
  logic               opaque;

  assign last_col = (sx_reg == WIDTH_X'(SPRITE_W - 1));
  assign last_row = (sy_reg == WIDTH_Y'(SPRITE_H - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      sx_reg    <= '0;
      sy_reg    <= '0;
      pos_x_reg <= '0;
      pos_y_reg <= '0;
      flush_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sx_reg    <= sx_next;
      sy_reg    <= sy_next;
      pos_x_reg <= pos_x_next;
      pos_y_reg <= pos_y_next;
      flush_reg <= flush_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sx_next    = sx_reg;
    sy_next    = sy_reg;
    pos_x_next = pos_x_reg;
    pos_y_next = pos_y_reg;
    flush_next = flush_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          pos_x_next = bus.pos_x;
          pos_y_next = bus.pos_y;
          sx_next    = '0;
          sy_next    = '0;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (last_col && last_row) begin
          flush_next = 1'b0;
          state_next = FLUSH;
        end else if (last_col) begin
          sx_next = '0;
          sy_next = sy_reg + 1'b1;
        end else begin
          sx_next = sx_reg + 1'b1;
        end
      end
      FLUSH: begin
        // Two cycles: the last address needs one for ROM latency and one for the output register.
        if (flush_reg) begin
          state_next = DONE;
        end else begin
          flush_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign on_screen = (x1_reg < 9'(SCREEN_W)) && (y1_reg < 8'(SCREEN_H));
  assign opaque    = !(TRANSPARENT_EN && (bus.rom_color == TRANSPARENT));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid1_reg    <= 1'b0;
      x1_reg        <= '0;
      y1_reg        <= '0;
      plot_reg      <= 1'b0;
      vga_x_reg     <= '0;
      vga_y_reg     <= '0;
      vga_color_reg <= '0;
    end else begin
      valid1_reg <= (state_reg == DRAW);
      x1_reg     <= {1'b0, pos_x_reg} + 9'(sx_reg);
      y1_reg     <= {1'b0, pos_y_reg} + 8'(sy_reg);
      plot_reg   <= valid1_reg && on_screen && opaque;
      if (valid1_reg) begin
        vga_x_reg     <= x1_reg[7:0];
        vga_y_reg     <= y1_reg[6:0];
        vga_color_reg <= bus.rom_color;
      end
    end
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.rom_x     = sx_reg;
  assign bus.rom_y     = sy_reg;
  assign bus.plot      = plot_reg;
  assign bus.vga_x     = vga_x_reg;
  assign bus.vga_y     = vga_y_reg;
  assign bus.vga_color = vga_color_reg;

endmodule

// File: tb/tb_sprite_drawer.sv
// Scoreboard bench for sprite_drawer: expected plots are queued when a draw is started and
// matched in order against observed plot pulses; done timing and reset behaviour are checked too.
module tb_sprite_drawer;

  typedef struct {
    int x;
    int y;
    int c;
    int k;
  } pix_t;

  logic clk;
  logic resetn;
  int   rom_mode;
  int   checks;
  int   errors;

  pix_t exp_q[$];
  pix_t obs_q[$];
  int   done_k;
  int   done_cnt;
  int   busy_k1;
  int   busy_after;

  sprite_drawer_if #(.WIDTH_X(4), .WIDTH_Y(3)) if1 ();
  sprite_drawer_if #(.WIDTH_X(4), .WIDTH_Y(3)) if2 ();

  sprite_drawer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if1.slave)
  );

  sprite_drawer #(.TRANSPARENT_EN(1'b0)) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] rom_val(input int x, input int y, input int mode);
    case (mode)
      0:       rom_val = 3'b001;
      1:       rom_val = ((x == 0 && y == 0) || (x == 9 && y == 5)) ? 3'b000 : 3'((x + y) % 7 + 1);
      2:       rom_val = 3'b000;
      default: rom_val = 3'((x ^ y) % 7 + 1);
    endcase
  endfunction

  // Sprite ROM with one-cycle read latency for each DUT.
  always @(posedge clk) begin
    if1.rom_color <= rom_val(int'(if1.rom_x), int'(if1.rom_y), rom_mode);
    if2.rom_color <= rom_val(int'(if2.rom_x), int'(if2.rom_y), rom_mode);
  end

  task automatic push_expected(input int px, input int py, input int mode, input bit ten);
    pix_t p;
    for (int sy = 0; sy < 6; sy++) begin
      for (int sx = 0; sx < 10; sx++) begin
        p.x = px + sx;
        p.y = py + sy;
        p.c = int'(rom_val(sx, sy, mode));
        p.k = 0;
        if (p.x < 160 && p.y < 120 && !(ten && p.c == 0)) exp_q.push_back(p);
      end
    end
  endtask

  task automatic drive_start(input int sel, input int px, input int py);
    @(negedge clk);
    if (sel == 1) begin
      if1.start = 1'b1; if1.pos_x = 8'(px); if1.pos_y = 7'(py);
    end else begin
      if2.start = 1'b1; if2.pos_x = 8'(px); if2.pos_y = 7'(py);
    end
  endtask

  // Runs ncyc cycles after the start cycle, recording plots and done/busy observations.
  task automatic collect(input int sel, input int ncyc, input int repulse_k);
    pix_t p;
    bit   pl, dn, bz;
    obs_q.delete();
    done_k = -1; done_cnt = 0; busy_k1 = -1; busy_after = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if1.start = 1'b0;
      if2.start = 1'b0;
      pl  = (sel == 1) ? if1.plot : if2.plot;
      dn  = (sel == 1) ? if1.done : if2.done;
      bz  = (sel == 1) ? if1.busy : if2.busy;
      p.x = (sel == 1) ? int'(if1.vga_x) : int'(if2.vga_x);
      p.y = (sel == 1) ? int'(if1.vga_y) : int'(if2.vga_y);
      p.c = (sel == 1) ? int'(if1.vga_color) : int'(if2.vga_color);
      p.k = k;
      if (pl) obs_q.push_back(p);
      if (k == 1) busy_k1 = int'(bz);
      if (done_k >= 0 && k == done_k + 1) busy_after = int'(bz);
      if (dn) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == repulse_k) begin
        if (sel == 1) begin
          if1.start = 1'b1; if1.pos_x = 8'd0; if1.pos_y = 7'd0;
        end else begin
          if2.start = 1'b1; if2.pos_x = 8'd0; if2.pos_y = 7'd0;
        end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if1.busy, if1.done, if1.plot} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/plot=%b required 000", {if1.busy, if1.done, if1.plot});
    end
    checks++;
    if ({if1.vga_x, if1.vga_y, if1.vga_color, if1.rom_x, if1.rom_y} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: vga=(%0d,%0d,%0d) rom=(%0d,%0d) required all 0",
               if1.vga_x, if1.vga_y, if1.vga_color, if1.rom_x, if1.rom_y);
    end
    @(negedge clk);
    resetn = 1'b1;
    $display("reset: busy=%b done=%b plot=%b", if1.busy, if1.done, if1.plot);
  endtask

  task automatic test_draw(input string name, input int sel, input int px, input int py,
                           input int mode, input bit ten, input int nexp, input int repulse_k);
    int nobs;
    pix_t e;
    rom_mode = mode;
    exp_q.delete();
    push_expected(px, py, mode, ten);
    drive_start(sel, px, py);
    collect(sel, 70, repulse_k);
    nobs = obs_q.size();
    checks++;
    if (nobs != nexp || exp_q.size() != nexp) begin
      errors++;
      $display("FAIL %s_count: plots=%0d required %0d (model %0d)", name, nobs, nexp, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[0].x !== e.x || obs_q[0].y !== e.y || obs_q[0].c !== e.c) begin
        errors++;
        $display("FAIL %s_pixel: got (%0d,%0d,c%0d) at cycle %0d required (%0d,%0d,c%0d)",
                 name, obs_q[0].x, obs_q[0].y, obs_q[0].c, obs_q[0].k, e.x, e.y, e.c);
      end
      void'(obs_q.pop_front());
    end
    checks++;
    if (done_k !== 63 || done_cnt !== 1) begin
      errors++;
      $display("FAIL %s_done: done at cycle %0d count %0d required cycle 63 count 1", name, done_k, done_cnt);
    end
    checks++;
    if (busy_k1 !== 1 || busy_after !== 0) begin
      errors++;
      $display("FAIL %s_busy: busy after start=%0d after done=%0d required 1 and 0", name, busy_k1, busy_after);
    end
    $display("%s: pos=(%0d,%0d) plots=%0d done_cycle=%0d", name, px, py, nobs, done_k);
  endtask

  task automatic test_full_gapless();
    // Colour constant everywhere: 60 plots must occupy cycles 3..62 contiguously.
    int first_k, last_k, n;
    rom_mode = 0;
    exp_q.delete();
    push_expected(20, 30, 0, 1'b1);
    drive_start(1, 20, 30);
    collect(1, 70, -1);
    n = obs_q.size();
    first_k = (n > 0) ? obs_q[0].k : -1;
    last_k  = (n > 0) ? obs_q[n-1].k : -1;
    checks++;
    if (n != 60 || first_k != 3 || last_k != 62) begin
      errors++;
      $display("FAIL full_span: plots=%0d cycles %0d..%0d required 60 in 3..62", n, first_k, last_k);
    end
    checks++;
    if (n != 60 || obs_q[0].x != 20 || obs_q[0].y != 30 || obs_q[n-1].x != 29 || obs_q[n-1].y != 35) begin
      errors++;
      $display("FAIL full_corners: first/last not (20,30)/(29,35), plots=%0d", n);
    end
    checks++;
    if (done_k !== 63) begin
      errors++;
      $display("FAIL full_done: done at cycle %0d required 63", done_k);
    end
    $display("full: plots=%0d span %0d..%0d done_cycle=%0d", n, first_k, last_k, done_k);
  endtask

  task automatic test_reset_mid_draw();
    int n;
    pix_t e;
    rom_mode = 0;
    exp_q.delete();
    push_expected(20, 30, 0, 1'b1);
    drive_start(1, 20, 30);
    collect(1, 28, -1);
    n = obs_q.size();
    checks++;
    if (n != 26) begin
      errors++;
      $display("FAIL midreset_prefix: plots before reset=%0d required 26", n);
    end
    for (int i = 0; i < n && i < 26; i++) begin
      e = exp_q[i];
      checks++;
      if (obs_q[i].x !== e.x || obs_q[i].y !== e.y) begin
        errors++;
        $display("FAIL midreset_pixel: got (%0d,%0d) required (%0d,%0d)", obs_q[i].x, obs_q[i].y, e.x, e.y);
      end
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({if1.plot, if1.busy, if1.done} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_abort: plot/busy/done=%b required 000", {if1.plot, if1.busy, if1.done});
    end
    $display("midreset: aborted after %0d plots, plot=%b busy=%b", n, if1.plot, if1.busy);
    // Start rides on the first cycle out of reset.
    resetn = 1'b1;
    if1.start = 1'b1; if1.pos_x = 8'd40; if1.pos_y = 7'd50;
    exp_q.delete();
    push_expected(40, 50, 0, 1'b1);
    collect(1, 70, -1);
    n = obs_q.size();
    checks++;
    if (n != 60 || done_k !== 63 || done_cnt !== 1) begin
      errors++;
      $display("FAIL midreset_redraw: plots=%0d done at %0d count %0d required 60, 63, 1", n, done_k, done_cnt);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[0].x !== e.x || obs_q[0].y !== e.y) begin
        errors++;
        $display("FAIL midreset_redraw_pixel: got (%0d,%0d) required (%0d,%0d)", obs_q[0].x, obs_q[0].y, e.x, e.y);
      end
      void'(obs_q.pop_front());
    end
    $display("midreset_redraw: plots=%0d done_cycle=%0d", n, done_k);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rom_mode = 0;
    resetn = 1'b0;
    if1.start = 1'b0; if1.pos_x = '0; if1.pos_y = '0;
    if2.start = 1'b0; if2.pos_x = '0; if2.pos_y = '0;
    test_reset();
    test_full_gapless();
    test_draw("transparent", 1, 20, 30, 1, 1'b1, 58, -1);
    test_draw("clip", 1, 155, 117, 3, 1'b1, 15, -1);
    test_draw("repulse", 1, 70, 40, 3, 1'b1, 60, 10);
    test_reset_mid_draw();
    test_draw("transp_off", 2, 5, 7, 2, 1'b0, 60, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
